// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   localparam logic [DEF_WIDTH-1:0] MOST_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic {OP_MULT, OP_DIV} op_t;

endpackage

// File: rtl/multdiv_if.sv
// Operand/start/result bundle between the execute stage and multdiv_ctrl.
interface multdiv_if #(
   parameter int WIDTH = 32
);

   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY
   );

endinterface

// File: rtl/multdiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, sharing a single WIDTH-bit adder path.
module multdiv_step
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  op_t                op,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mag,
   input  logic               bit_in,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, mag} : '0);
      rem_sh   = {acc[2*WIDTH-1:WIDTH], bit_in};
      diff     = {1'b0, rem_sh} - {2'b00, mag};
      q_bit    = 1'b0;
      acc_next = acc;
      if (op == OP_MULT) begin
         // Carry out of the add becomes the new MSB as the pair shifts right.
         acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
         q_bit    = ~diff[WIDTH+1];
         acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc[WIDTH-2:0], q_bit};
      end
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide controller: FSM, counter, sign fix-up, exceptions.
// Optional build macro MULTDIV_EARLY_TERM_EN stops multiply once no multiplier bits remain.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic      clock,
   input logic      reset,
   multdiv_if.slave bus
);

   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   state_t                    state, state_nxt;
   op_t                       op;
   logic [CNT_W-1:0]          cnt;
   logic [2*WIDTH-1:0]        acc, acc_step;
   logic [WIDTH-1:0]          mag;
   logic                      sign, div_ovf;
   logic                      start, div_zero, last_iter, early, q_bit;
   logic [WIDTH-1:0]          mag_a, mag_b;
   logic [2*WIDTH-1:0]        prod_mag;
   logic signed [2*WIDTH-1:0] prod_sgn;
   logic [WIDTH-1:0]          quo_sgn;
   logic [WIDTH-1:0]          fin_result;
   logic                      fin_exc;
   logic [WIDTH-1:0]          result_r;
   logic                      exc_r;
`ifdef MULTDIV_EARLY_TERM_EN
   logic [WIDTH-2:0]          mq_rest;
`endif

   assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
   assign div_zero = bus.ctrl_DIV & ~bus.ctrl_MULT & (bus.data_operandB == '0);
   assign mag_a    = mag_of(bus.data_operandA);
   assign mag_b    = mag_of(bus.data_operandB);

`ifdef MULTDIV_EARLY_TERM_EN
   assign early = (op == OP_MULT) && (mq_rest == '0);
`else
   assign early = 1'b0;
`endif
   assign last_iter = (cnt == LAST_CNT) | early;

   multdiv_step #(.WIDTH(WIDTH)) u_step (
      .op       (op),
      .acc      (acc),
      .mag      (mag),
      .bit_in   ((op == OP_MULT) ? acc[0] : acc[WIDTH-1]),
      .acc_next (acc_step),
      .q_bit    (q_bit)
   );

   // Final-iteration result: realign an early-terminated product, then apply sign.
   always_comb begin
      prod_mag = acc_step;
`ifdef MULTDIV_EARLY_TERM_EN
      prod_mag = acc_step >> (LAST_CNT - cnt);
`endif
      prod_sgn = sign ? -prod_mag : prod_mag;
      quo_sgn  = sign ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      if (op == OP_MULT) begin
         fin_result = prod_sgn[WIDTH-1:0];
         fin_exc    = prod_sgn[2*WIDTH-1:WIDTH] != {WIDTH{prod_sgn[WIDTH-1]}};
      end else begin
         fin_result = quo_sgn;
         fin_exc    = div_ovf;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         RUN:     if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A start pulse overrides whatever is in flight.
      if (start) state_nxt = div_zero ? DONE : RUN;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         op       <= OP_MULT;
         cnt      <= '0;
         acc      <= '0;
         mag      <= '0;
         sign     <= 1'b0;
         div_ovf  <= 1'b0;
         result_r <= '0;
         exc_r    <= 1'b0;
`ifdef MULTDIV_EARLY_TERM_EN
         mq_rest  <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (start) begin
            op      <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
            cnt     <= '0;
            sign    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div_ovf <= (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
            mag     <= bus.ctrl_MULT ? mag_a : mag_b;
            acc     <= {{WIDTH{1'b0}}, (bus.ctrl_MULT ? mag_b : mag_a)};
`ifdef MULTDIV_EARLY_TERM_EN
            mq_rest <= mag_b[WIDTH-1:1];
`endif
            if (div_zero) begin
               result_r <= '0;
               exc_r    <= 1'b1;
            end
         end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
`ifdef MULTDIV_EARLY_TERM_EN
            mq_rest <= mq_rest >> 1;
`endif
            if (last_iter) begin
               result_r <= fin_result;
               exc_r    <= fin_exc;
            end
         end
      end
   end

   assign bus.data_result    = result_r;
   assign bus.data_exception = exc_r;
   assign bus.data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl; expected latencies follow MULTDIV_EARLY_TERM_EN.
module tb_multdiv_ctrl;
   import multdiv_pkg::*;

`ifdef MULTDIV_EARLY_TERM_EN
   localparam int LAT_NEG  = 4;
   localparam int LAT_OVF  = 18;
   localparam int LAT_BOTH = 4;
   localparam int LAT_TWO  = 3;
`else
   localparam int LAT_NEG  = 33;
   localparam int LAT_OVF  = 33;
   localparam int LAT_BOTH = 33;
   localparam int LAT_TWO  = 33;
`endif
   localparam int LAT_DIV = 33;

   logic clock;
   logic reset;
   int   checks;
   int   fails;

   multdiv_if #(.WIDTH(32)) bus ();

   multdiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      bus.data_operandA = a;
      bus.data_operandB = b;
      tick();
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
   endtask

   // Observes cycles 1..max after a start; records the first RDY and counts all RDYs.
   task automatic wait_rdy(input int max, output int first, output int n,
                           output logic [31:0] res, output logic exc);
      first = -1;
      n     = 0;
      res   = '0;
      exc   = 1'b0;
      for (int c = 1; c <= max; c++) begin
         if (bus.data_resultRDY === 1'b1) begin
            n++;
            if (first < 0) begin
               first = c;
               res   = bus.data_result;
               exc   = bus.data_exception;
            end
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (bus.data_resultRDY !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY); end
      checks++; if (bus.data_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", bus.data_result); end
      checks++; if (bus.data_exception !== 1'b0) begin fails++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mult_neg();
      int first, n; logic [31:0] res; logic exc;
      start_op(1'b1, 1'b0, 32'd7, -32'sd6);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== LAT_NEG) begin fails++; $display("FAIL mult_neg_cycle: got %0d expected %0d", first, LAT_NEG); end
      checks++; if (n !== 1) begin fails++; $display("FAIL mult_neg_rdy_count: got %0d expected 1", n); end
      checks++; if (res !== 32'hFFFFFFD6) begin fails++; $display("FAIL mult_neg_result: got %h expected FFFFFFD6", res); end
      checks++; if (exc !== 1'b0) begin fails++; $display("FAIL mult_neg_exc: got %b expected 0", exc); end
      checks++; if (bus.data_result !== 32'hFFFFFFD6) begin fails++; $display("FAIL mult_neg_hold: got %h expected FFFFFFD6", bus.data_result); end
   endtask

   task automatic test_mult_ovf();
      int first, n; logic [31:0] res; logic exc;
      start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== LAT_OVF) begin fails++; $display("FAIL mult_ovf_cycle: got %0d expected %0d", first, LAT_OVF); end
      checks++; if (n !== 1) begin fails++; $display("FAIL mult_ovf_rdy_count: got %0d expected 1", n); end
      checks++; if (res !== 32'h0) begin fails++; $display("FAIL mult_ovf_result: got %h expected 00000000", res); end
      checks++; if (exc !== 1'b1) begin fails++; $display("FAIL mult_ovf_exc: got %b expected 1", exc); end
   endtask

   task automatic test_div_signed();
      int first, n; logic [31:0] res; logic exc;
      start_op(1'b0, 1'b1, -32'sd100, 32'd7);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== LAT_DIV) begin fails++; $display("FAIL div_signed_cycle: got %0d expected %0d", first, LAT_DIV); end
      checks++; if (n !== 1) begin fails++; $display("FAIL div_signed_rdy_count: got %0d expected 1", n); end
      checks++; if (res !== 32'hFFFFFFF2) begin fails++; $display("FAIL div_signed_result: got %h expected FFFFFFF2", res); end
      checks++; if (exc !== 1'b0) begin fails++; $display("FAIL div_signed_exc: got %b expected 0", exc); end
   endtask

   task automatic test_div_zero();
      int first, n; logic [31:0] res; logic exc;
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== 1) begin fails++; $display("FAIL div_zero_cycle: got %0d expected 1", first); end
      checks++; if (n !== 1) begin fails++; $display("FAIL div_zero_rdy_count: got %0d expected 1", n); end
      checks++; if (res !== 32'h0) begin fails++; $display("FAIL div_zero_result: got %h expected 00000000", res); end
      checks++; if (exc !== 1'b1) begin fails++; $display("FAIL div_zero_exc: got %b expected 1", exc); end
   endtask

   task automatic test_div_minneg();
      int first, n; logic [31:0] res; logic exc;
      start_op(1'b0, 1'b1, MOST_NEG, 32'hFFFFFFFF);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== LAT_DIV) begin fails++; $display("FAIL div_minneg_cycle: got %0d expected %0d", first, LAT_DIV); end
      checks++; if (res !== 32'h80000000) begin fails++; $display("FAIL div_minneg_result: got %h expected 80000000", res); end
      checks++; if (exc !== 1'b1) begin fails++; $display("FAIL div_minneg_exc: got %b expected 1", exc); end
   endtask

   task automatic test_abort();
      int first, n, early_rdy; logic [31:0] res; logic exc;
      early_rdy = 0;
      start_op(1'b1, 1'b0, 32'd5, 32'h7FFFFFFF);
      for (int c = 1; c < 10; c++) begin
         if (bus.data_resultRDY === 1'b1) early_rdy++;
         tick();
      end
      if (bus.data_resultRDY === 1'b1) early_rdy++;
      start_op(1'b0, 1'b1, 32'd9, 32'd2);
      wait_rdy(40, first, n, res, exc);
      checks++; if (early_rdy !== 0) begin fails++; $display("FAIL abort_no_rdy: got %0d expected 0", early_rdy); end
      checks++; if (first + 10 !== 43) begin fails++; $display("FAIL abort_cycle: got %0d expected 43", first + 10); end
      checks++; if (n !== 1) begin fails++; $display("FAIL abort_rdy_count: got %0d expected 1", n); end
      checks++; if (res !== 32'd4) begin fails++; $display("FAIL abort_result: got %h expected 00000004", res); end
   endtask

   task automatic test_both_pulses();
      int first, n; logic [31:0] res; logic exc;
      start_op(1'b1, 1'b1, 32'd3, 32'd4);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== LAT_BOTH) begin fails++; $display("FAIL both_cycle: got %0d expected %0d", first, LAT_BOTH); end
      checks++; if (res !== 32'd12) begin fails++; $display("FAIL both_result: got %h expected 0000000C", res); end
      checks++; if (exc !== 1'b0) begin fails++; $display("FAIL both_exc: got %b expected 0", exc); end
   endtask

   task automatic test_reset_mid();
      int first, n, stray; logic [31:0] res; logic exc;
      stray = 0;
      start_op(1'b1, 1'b0, 32'd3, 32'h40000000);
      for (int c = 1; c < 20; c++) begin
         if (bus.data_resultRDY === 1'b1) stray++;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.data_resultRDY !== 1'b0) begin fails++; $display("FAIL mid_reset_rdy: got %b expected 0", bus.data_resultRDY); end
      checks++; if (bus.data_result !== 32'h0) begin fails++; $display("FAIL mid_reset_result: got %h expected 00000000", bus.data_result); end
      checks++; if (bus.data_exception !== 1'b0) begin fails++; $display("FAIL mid_reset_exc: got %b expected 0", bus.data_exception); end
      for (int c = 0; c < 50; c++) begin
         if (bus.data_resultRDY === 1'b1) stray++;
         tick();
      end
      checks++; if (stray !== 0) begin fails++; $display("FAIL mid_reset_no_rdy: got %0d expected 0", stray); end
      start_op(1'b1, 1'b0, 32'd2, 32'd2);
      wait_rdy(40, first, n, res, exc);
      checks++; if (first !== LAT_TWO) begin fails++; $display("FAIL post_reset_cycle: got %0d expected %0d", first, LAT_TWO); end
      checks++; if (n !== 1) begin fails++; $display("FAIL post_reset_rdy_count: got %0d expected 1", n); end
      checks++; if (res !== 32'd4) begin fails++; $display("FAIL post_reset_result: got %h expected 00000004", res); end
   endtask

   initial begin
      checks            = 0;
      fails             = 0;
      reset             = 1'b1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      test_reset();
      test_mult_neg();
      test_mult_ovf();
      test_div_signed();
      test_div_zero();
      test_div_minneg();
      test_abort();
      test_both_pulses();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Iterative signed multiply/divide unit for the processor's ALU. It sequences a single shared WIDTH-bit add/subtract step over WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide. The block sits beside the combinational ALU in execute, and the pipeline stalls on it until data_resultRDY is asserted. It is the team's first multi-cycle ALU resource.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; sampled on the rising edge of clock
data_operandA  input  WIDTH  multiplicand / dividend; sampled only in the start cycle
data_operandB  input  WIDTH  multiplier / divisor; sampled only in the start cycle
ctrl_MULT  input  1  one-cycle start pulse, signed multiply
ctrl_DIV  input  1  one-cycle start pulse, signed divide
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY=1
data_resultRDY  output  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE; data_result, data_exception, data_resultRDY, counter and internal registers all 0. Reset during RUN aborts the operation, and no RDY is ever issued for it.
- States:
  - IDLE: waits for a start pulse.
  - RUN: iterates.
  - DONE: asserts RDY for one cycle, then returns to IDLE.
- Start: ctrl_MULT or ctrl_DIV high at a rising edge is a start in any state.
  - Operands are latched and the op is recorded.
  - The counter is cleared and the FSM enters RUN.
  - A start in RUN or DONE aborts the current op; no RDY is issued for the aborted op.
  - If both pulses are high in the same cycle, MULT wins and DIV is ignored.
- Signs: operands are converted to magnitudes and sign = A[W-1]^B[W-1]. The final result is two's-complemented if the sign is 1.
- Multiply:
  - One conditional add of the magnitude of A per cycle into a 2*WIDTH accumulator, shifting right; WIDTH iterations.
  - data_resultRDY is high during cycle WIDTH+1 after the start cycle (start cycle = cycle 0).
  - Exception=1 if the signed 2*WIDTH product is not the sign-extension of its low WIDTH bits. Result = low WIDTH bits regardless.
- Divide:
  - Restoring division, one trial subtract per cycle; same latency as multiply.
  - Quotient truncates toward zero; the remainder is discarded.
  - Divisor==0: result=0, exception=1, RDY in cycle 1 (RUN is skipped; IDLE→DONE).
  - Most-negative dividend / -1: result=0x80000000 (for WIDTH=32), exception=1, normal latency.
- Outputs:
  - data_result and data_exception update on entry to DONE and hold until the next start or reset.
  - They read 0 after reset until the first completion.
  - data_resultRDY is high only in DONE, for exactly one cycle per completed op.
- Counter wraps are never observed: RUN exits when counter==WIDTH-1.

Optional Feature:
MULTDIV_EARLY_TERM_EN
- Defined: multiply leaves RUN once the remaining unshifted multiplier-magnitude bits are all 0, with a minimum of 1 iteration. RDY then arrives in cycle k+1, where k = max(1, index of the highest set bit of |B| + 1).
  - Example: B=3 gives RDY in cycle 3.
  - Example: B=0 gives RDY in cycle 2 with result 0.
  - Result and exception are identical to the full run.
- Undefined: every multiply takes exactly WIDTH iterations.
- Divide latency is unaffected in both cases.

Decomposition:
- Package multdiv_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the op enum (OP_MULT, OP_DIV);
  - default WIDTH/CNT_W localparams;
  - the most-negative constant.
- Sub-module multdiv_step: combinational single iteration. Inputs are op, accumulator/remainder, operand magnitude and the current bit. Outputs are the next accumulator/remainder and the quotient bit.
- The FSM, counter, sign fix-up and exception logic live in multdiv_ctrl.

Test Plan:
- Multiply with a negative operand: ctrl_MULT, A=7, B=-6 → cycle 33: result=0xFFFFFFD6, exception=0, RDY for exactly 1 cycle. With the macro defined, RDY arrives in cycle 4 with the same values.
- Multiply overflow: ctrl_MULT, A=0x00010000, B=0x00010000 → result=0x00000000, exception=1 at cycle 33.
- Signed divide: ctrl_DIV, A=-100, B=7 → result=0xFFFFFFF2 (-14), exception=0 at cycle 33.
- Divide corner cases:
  - ctrl_DIV, A=5, B=0 → RDY in cycle 1, result=0, exception=1.
  - ctrl_DIV, A=0x80000000, B=-1 → result=0x80000000, exception=1.
- Abort by restart: ctrl_MULT at cycle 0, then ctrl_DIV with A=9, B=2 at cycle 10 → exactly one RDY, at cycle 43, with result=4. Both pulses in one cycle with A=3, B=4 → result=12.
- Reset mid-operation: reset at cycle 20 of a multiply → no RDY ever. All outputs read 0 on the cycle after reset. A following start with A=2, B=2 completes normally with result=4.
